// File: rtl/esc_pkg.sv
// Shared types, defaults and helpers for the ESC pulse bank.
//   spd_t / off_t : container types wide enough for any supported speed/offset field
//   ESC_MIN_PULSE_DFLT : default pulse width (cycles) at compensated speed 0
//   sat_add() : speed + trim offset, saturated to the all-ones value of an spd_w-bit field
package esc_pkg;

  localparam int unsigned ESC_MIN_PULSE_DFLT = 50000;
  localparam int unsigned ESC_FIELD_W_MAX    = 16;

  typedef logic [ESC_FIELD_W_MAX-1:0] spd_t;
  typedef logic [ESC_FIELD_W_MAX-1:0] off_t;

  // Both operands are zero-extended; the result never exceeds 2**spd_w-1.
  function automatic spd_t sat_add(input spd_t spd, input off_t off, input int unsigned spd_w);
    logic [ESC_FIELD_W_MAX:0] sum;
    logic [ESC_FIELD_W_MAX:0] lim;
    sum = {1'b0, spd} + {1'b0, off};
    lim = ((ESC_FIELD_W_MAX + 1)'(1) << spd_w) - (ESC_FIELD_W_MAX + 1)'(1);
    return (sum > lim) ? lim[ESC_FIELD_W_MAX-1:0] : sum[ESC_FIELD_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/esc_chan.sv
// One ESC output channel: staging and active registers, optional slew, pulse width
// computation and the registered pulse output.
// Optional feature macro: ESC_SLEW_EN (active moves toward target by at most SLEW_STEP per frame).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   spd, off     this channel's speed and trim offset from the bus
//   spd_vld      capture spd/off into staging
//   wrap         frame counter is all-ones this cycle
//   apply        active takes its update on this wrap
//   motors_off   force output low from the next edge
//   hold         no pulse may start before the next wrap
//   cnt_nxt      frame counter value after this edge
//   settled      active equals the target after this apply
//   esc_out      registered pulse output
module esc_chan
  import esc_pkg::*;
#(
  parameter int unsigned SPD_W     = 11,
  parameter int unsigned OFF_W     = 10,
  parameter int unsigned PERIOD_W  = 20,
  parameter int unsigned MIN_PULSE = ESC_MIN_PULSE_DFLT,
  parameter int unsigned SCALE     = 3,
  parameter int unsigned SLEW_STEP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SPD_W-1:0]    spd,
  input  logic [OFF_W-1:0]    off,
  input  logic                spd_vld,
  input  logic                wrap,
  input  logic                apply,
  input  logic                motors_off,
  input  logic                hold,
  input  logic [PERIOD_W-1:0] cnt_nxt,
  output logic                settled,
  output logic                esc_out
);

  if (SLEW_STEP >= (2 ** SPD_W)) begin : gen_step_chk
    $warning("esc_chan: SLEW_STEP spans the full speed range, every update is a single step");
  end

  logic [SPD_W-1:0]    stg_spd_q;
  logic [OFF_W-1:0]    stg_off_q;
  logic [SPD_W-1:0]    act_q, act_d, act_nxt, tgt;
  logic [SPD_W-1:0]    src_spd;
  logic [OFF_W-1:0]    src_off;
  logic [PERIOD_W-1:0] width_q, width_d;
  logic                esc_out_q, esc_out_d;

  // A capture coinciding with the wrap bypasses staging and is applied directly.
  assign src_spd = spd_vld ? spd : stg_spd_q;
  assign src_off = spd_vld ? off : stg_off_q;
  assign tgt     = SPD_W'(sat_add(spd_t'(src_spd), off_t'(src_off), SPD_W));

`ifdef ESC_SLEW_EN
  localparam int unsigned StepSat = (SLEW_STEP >= (2 ** SPD_W)) ? (2 ** SPD_W) - 1 : SLEW_STEP;
  localparam logic [SPD_W:0] StepLim = (SPD_W + 1)'(StepSat);

  logic [SPD_W:0] diff;

  always_comb begin
    act_nxt = tgt;
    if (tgt > act_q) begin
      diff = {1'b0, tgt} - {1'b0, act_q};
      if (diff > StepLim) act_nxt = SPD_W'({1'b0, act_q} + StepLim);
    end else begin
      diff = {1'b0, act_q} - {1'b0, tgt};
      if (diff > StepLim) act_nxt = SPD_W'({1'b0, act_q} - StepLim);
    end
  end
`else
  assign act_nxt = tgt;
`endif

  assign settled = (act_nxt == tgt);
  assign act_d   = apply ? act_nxt : act_q;

  // Latched at the wrap so a mid-frame update cannot reshape the pulse in flight.
  assign width_d = PERIOD_W'(MIN_PULSE) + PERIOD_W'(SCALE) * PERIOD_W'(act_d);

  always_comb begin
    esc_out_d = esc_out_q;
    if (motors_off) begin
      esc_out_d = 1'b0;
    end else if (wrap) begin
      esc_out_d = (width_d != '0);
    end else if (hold) begin
      esc_out_d = 1'b0;
    end else if (cnt_nxt == width_q) begin
      esc_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_spd_q <= '0;
      stg_off_q <= '0;
      act_q     <= '0;
      width_q   <= '0;
      esc_out_q <= 1'b0;
    end else begin
      if (spd_vld) begin
        stg_spd_q <= spd;
        stg_off_q <= off;
      end
      if (apply) act_q <= act_nxt;
      if (wrap) width_q <= width_d;
      esc_out_q <= esc_out_d;
    end
  end

  assign esc_out = esc_out_q;

endmodule

// File: rtl/esc_pwm_bank.sv
// N-channel ESC pulse generator. Each frame of 2**PERIOD_W cycles every channel emits one
// pulse of MIN_PULSE + SCALE*clamp(spd+off) cycles; speeds are double-buffered and applied
// only at the frame wrap.
// Optional feature macro: ESC_SLEW_EN (rate-limit active speed changes to SLEW_STEP per frame).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   spd         packed speeds, ch0 in LSBs
//   off         packed trim offsets, ch0 in LSBs
//   spd_vld     capture spd/off into staging
//   motors_off  force all outputs low
//   esc_out     registered pulse per channel
//   frame_strt  high in the cycle where the frame counter is 0
//   upd_pend    staged values not yet fully applied
module esc_pwm_bank
  import esc_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SPD_W     = 11,
  parameter int unsigned OFF_W     = 10,
  parameter int unsigned PERIOD_W  = 20,
  parameter int unsigned MIN_PULSE = ESC_MIN_PULSE_DFLT,
  parameter int unsigned SCALE     = 3,
  parameter int unsigned SLEW_STEP = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*SPD_W-1:0] spd,
  input  logic [NUM_CH*OFF_W-1:0] off,
  input  logic                    spd_vld,
  input  logic                    motors_off,
  output logic [NUM_CH-1:0]       esc_out,
  output logic                    frame_strt,
  output logic                    upd_pend
);

  localparam longint unsigned MaxWidth =
      longint'(MIN_PULSE) + longint'(SCALE) * ((64'd1 << SPD_W) - 64'd1);

  if (MaxWidth >= (64'd1 << PERIOD_W)) begin : gen_width_chk
    $error("esc_pwm_bank: widest pulse does not fit in one frame");
  end
  if (SPD_W > ESC_FIELD_W_MAX || OFF_W > ESC_FIELD_W_MAX) begin : gen_field_chk
    $error("esc_pwm_bank: SPD_W/OFF_W exceed the esc_pkg field width");
  end

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                wrap, apply;
  logic                hold_q, hold_d;
  logic                upd_pend_q, upd_pend_d;
  logic                frame_strt_q;
  logic [NUM_CH-1:0]   settled;

  assign cnt_d = cnt_q + PERIOD_W'(1);
  assign wrap  = &cnt_q;
  assign apply = wrap & (upd_pend_q | spd_vld);

  always_comb begin
    upd_pend_d = upd_pend_q;
    if (apply) begin
      upd_pend_d = ~&settled;
    end else if (spd_vld) begin
      upd_pend_d = 1'b1;
    end
  end

  // Hold suppresses any pulse until a clean frame start after motors_off is released.
  always_comb begin
    hold_d = hold_q;
    if (motors_off) begin
      hold_d = 1'b1;
    end else if (wrap) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      hold_q       <= 1'b1;
      upd_pend_q   <= 1'b0;
      frame_strt_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      upd_pend_q   <= upd_pend_d;
      frame_strt_q <= wrap;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_chan
    esc_chan #(
      .SPD_W     (SPD_W),
      .OFF_W     (OFF_W),
      .PERIOD_W  (PERIOD_W),
      .MIN_PULSE (MIN_PULSE),
      .SCALE     (SCALE),
      .SLEW_STEP (SLEW_STEP)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .spd        (spd[i*SPD_W +: SPD_W]),
      .off        (off[i*OFF_W +: OFF_W]),
      .spd_vld    (spd_vld),
      .wrap       (wrap),
      .apply      (apply),
      .motors_off (motors_off),
      .hold       (hold_q),
      .cnt_nxt    (cnt_d),
      .settled    (settled[i]),
      .esc_out    (esc_out[i])
    );
  end

  assign frame_strt = frame_strt_q;
  assign upd_pend   = upd_pend_q;

endmodule
